// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the multi-master APB arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR
  } state_e;

  localparam int APB_DW = 32;

  // True when exactly one bit is set; callers zero-extend narrower vectors.
  function automatic logic is_onehot(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/apb_rr_arb_core.sv
// Round-robin pick: first requester at or after the pointer, cyclically.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module apb_rr_arb_core #(
  parameter int NUM_MST = 2
) (
  input  logic [NUM_MST-1:0]         i_req,
  input  logic [$clog2(NUM_MST)-1:0] i_ptr,
  output logic [NUM_MST-1:0]         o_gnt,
  output logic [$clog2(NUM_MST)-1:0] o_gnt_idx
);

  localparam int IW = $clog2(NUM_MST);

  // Scan from the pointer around the ring and keep the first requester found.
  always_comb begin
    logic w_found;
    int   w_c;
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_c       = 0;
    for (int k = 0; k < NUM_MST; k++) begin
      w_c = (int'(i_ptr) + k) % NUM_MST;
      if (!w_found && i_req[w_c]) begin
        w_found        = 1'b1;
        o_gnt[w_c]     = 1'b1;
        o_gnt_idx      = IW'(w_c);
      end
    end
  end

endmodule

// File: rtl/apb_mst_arbiter.sv
// Shares one APB bus between NUM_MST masters, round-robin per transfer, with PREADY timeout.
// Latency: upstream SETUP cycle 0 -> downstream SETUP cycle 1 -> ACCESS cycle 2 (zero-wait PREADY back in cycle 2).
// Backpressure: losing masters see PREADY low and sit in legal APB wait states until granted.
module apb_mst_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_MST        = 2,
  parameter int APB_NUM_SLAVES = 8,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [NUM_MST-1:0][APB_NUM_SLAVES-1:0]       s_psel,
  input  logic [NUM_MST-1:0]                           s_penable,
  input  logic [NUM_MST-1:0]                           s_pwrite,
  input  logic [NUM_MST-1:0][APB_ADDR_WIDTH-1:0]       s_paddr,
  input  logic [NUM_MST-1:0][APB_DW-1:0]               s_pwdata,
  output logic [NUM_MST-1:0][APB_DW-1:0]               s_prdata,
  output logic [NUM_MST-1:0]                           s_pready,
  output logic [NUM_MST-1:0]                           s_pslverr,
  output logic                                         m_penable,
  output logic                                         m_pwrite,
  output logic [APB_ADDR_WIDTH-1:0]                    m_paddr,
  output logic [APB_NUM_SLAVES-1:0]                    m_psel,
  output logic [APB_DW-1:0]                            m_pwdata,
  input  logic [APB_NUM_SLAVES-1:0][APB_DW-1:0]        m_prdata,
  input  logic [APB_NUM_SLAVES-1:0]                    m_pready,
  input  logic [APB_NUM_SLAVES-1:0]                    m_pslverr,
  output logic [NUM_MST-1:0]                           grant_o,
  output logic                                         busy_o
);

  localparam int IW = $clog2(NUM_MST);
  localparam int SW = $clog2(APB_NUM_SLAVES);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                    r_state, w_state_nxt;
  logic [IW-1:0]             r_ptr, r_win_idx, w_gnt_idx, w_ptr_nxt;
  logic [NUM_MST-1:0]        r_win, w_gnt, w_req;
  logic [APB_NUM_SLAVES-1:0] r_psel, w_sel_win;
  logic [SW-1:0]             r_sidx, w_sidx;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic                      r_pwrite;
  logic [APB_DW-1:0]         r_pwdata;
  logic [CW-1:0]             r_cnt;
  logic                      w_sel_ok, w_done;

  // A master requests whenever any of its select lines is high.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_MST; i++) w_req[i] = |s_psel[i];
  end

  apb_rr_arb_core #(.NUM_MST(NUM_MST)) u_rr (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Encode the winner's select into a slave index and vet it for one-hotness.
  always_comb begin
    w_sel_win = s_psel[w_gnt_idx];
    w_sidx    = '0;
    for (int j = 0; j < APB_NUM_SLAVES; j++) begin
      if (w_sel_win[j]) w_sidx = SW'(j);
    end
    w_sel_ok  = is_onehot(64'(w_sel_win));
  end

  assign w_ptr_nxt = (r_win_idx == IW'(NUM_MST - 1)) ? '0 : r_win_idx + 1'b1;

  // State register; reset abandons any downstream transfer immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and all bus outputs; outputs are gated by state so IDLE drives zeros.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    s_prdata    = '0;
    s_pready    = '0;
    s_pslverr   = '0;
    m_penable   = 1'b0;
    m_pwrite    = 1'b0;
    m_paddr     = '0;
    m_psel      = '0;
    m_pwdata    = '0;
    grant_o     = (r_state != IDLE) ? r_win : '0;
    busy_o      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (|w_req) w_state_nxt = w_sel_ok ? SETUP : ERR;
      end
      SETUP: begin
        m_psel      = r_psel;
        m_pwrite    = r_pwrite;
        m_paddr     = r_paddr;
        m_pwdata    = r_pwdata;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        m_psel    = r_psel;
        m_penable = 1'b1;
        m_pwrite  = r_pwrite;
        m_paddr   = r_paddr;
        m_pwdata  = r_pwdata;
        // A real slave response beats a coincident timeout.
        if (m_pready[r_sidx]) begin
          s_pready[r_win_idx]  = 1'b1;
          s_prdata[r_win_idx]  = m_prdata[r_sidx];
          s_pslverr[r_win_idx] = m_pslverr[r_sidx];
          w_done               = 1'b1;
          w_state_nxt          = IDLE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          s_pready[r_win_idx]  = 1'b1;
          s_pslverr[r_win_idx] = 1'b1;
          w_done               = 1'b1;
          w_state_nxt          = IDLE;
        end
      end
      ERR: begin
        s_pready[r_win_idx]  = 1'b1;
        s_pslverr[r_win_idx] = 1'b1;
        w_done               = 1'b1;
        w_state_nxt          = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the winning transfer, run the saturating timeout counter, advance the pointer on completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr     <= '0;
      r_win_idx <= '0;
      r_win     <= '0;
      r_psel    <= '0;
      r_sidx    <= '0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_cnt     <= '0;
    end else begin
      if ((r_state == IDLE) && (|w_req)) begin
        r_win_idx <= w_gnt_idx;
        r_win     <= w_gnt;
        r_psel    <= w_sel_win;
        r_sidx    <= w_sidx;
        r_paddr   <= s_paddr[w_gnt_idx];
        r_pwrite  <= s_pwrite[w_gnt_idx];
        r_pwdata  <= s_pwdata[w_gnt_idx];
      end
      if (r_state == SETUP)                          r_cnt <= '0;
      else if ((r_state == ACCESS) && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      if (w_done) r_ptr <= w_ptr_nxt;
    end
  end

  // Upstream masters may only raise PENABLE while they are selecting a slave.
  for (genvar g = 0; g < NUM_MST; g++) begin : g_chk
    a_penable_with_psel: assert property (@(posedge clk_i) disable iff (rst_i)
      s_penable[g] |-> (|s_psel[g]));
  end

endmodule

// File: tb/tb_apb_mst_arbiter.sv
// Scoreboard bench for apb_mst_arbiter: directed transfers, contention, waits, timeout, bad select, reset.
// Latency: checks exact cycle positions of downstream SETUP/ACCESS and upstream PREADY.
// Backpressure: upstream masters hold their request until their own PREADY is seen.
module tb_apb_mst_arbiter;

  localparam int NM = 2;
  localparam int NS = 8;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NM-1:0][NS-1:0] s_psel;
  logic [NM-1:0]         s_penable, s_pwrite;
  logic [NM-1:0][AW-1:0] s_paddr;
  logic [NM-1:0][31:0]   s_pwdata, s_prdata;
  logic [NM-1:0]         s_pready, s_pslverr;
  logic                  m_penable, m_pwrite;
  logic [AW-1:0]         m_paddr;
  logic [NS-1:0]         m_psel;
  logic [31:0]           m_pwdata;
  logic [NS-1:0][31:0]   m_prdata;
  logic [NS-1:0]         m_pready, m_pslverr;
  logic [NM-1:0]         grant_o;
  logic                  busy_o;

  apb_mst_arbiter #(
    .NUM_MST(NM), .APB_NUM_SLAVES(NS), .APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_psel(m_psel), .m_pwdata(m_pwdata),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          m;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        sbq[$];
  string       dq_name[$];
  logic [31:0] dq_act[$];
  logic [31:0] dq_exp[$];

  int          n_tests  = 0;
  int          n_fail   = 0;
  logic        end_req  = 1'b0;
  logic        mon_done = 1'b0;
  logic [NM-1:0] ack    = '0;
  logic [NS-1:0] rdy_nxt = '1;

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
    end
  endtask

  // Monitor: compares every upstream completion against the scoreboard and drains queued point checks.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && (s_pready != '0)) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: s_pready=%b with no response expected", s_pready);
      end else begin
        e = sbq.pop_front();
        cmp("rsp_owner",   32'(s_pready), 32'(1) << e.m);
        cmp("rsp_prdata",  s_prdata[e.m], e.rdata);
        cmp("rsp_pslverr", 32'(s_pslverr[e.m]), 32'(e.err));
      end
    end
    while (dq_name.size() > 0) cmp(dq_name.pop_front(), dq_act.pop_front(), dq_exp.pop_front());
    if (end_req && !mon_done) begin
      cmp("sb_leftover", 32'(sbq.size()), 32'd0);
      mon_done = 1'b1;
    end
  end

  task automatic dchk(input string nm, input logic [31:0] a, input logic [31:0] e);
    dq_name.push_back(nm);
    dq_act.push_back(a);
    dq_exp.push_back(e);
  endtask

  task automatic exp_rsp(input int m, input logic [31:0] rd, input logic er);
    rsp_t r;
    r.m = m; r.rdata = rd; r.err = er;
    sbq.push_back(r);
  endtask

  task automatic req(input int m, input logic [AW-1:0] a, input logic w,
                     input logic [31:0] d, input logic [NS-1:0] sel);
    s_paddr[m]   = a;
    s_pwrite[m]  = w;
    s_pwdata[m]  = d;
    s_psel[m]    = sel;
    s_penable[m] = 1'b0;
  endtask

  // One clock: update slave ready and the upstream masters' APB phases, then sample at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    m_pready = rdy_nxt;
    for (int m = 0; m < NM; m++) begin
      if (ack[m]) begin
        s_psel[m]    = '0;
        s_penable[m] = 1'b0;
      end else if (s_psel[m] != '0) begin
        s_penable[m] = 1'b1;
      end
    end
    @(negedge clk);
    ack = s_pready;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (((s_psel != '0) || busy_o) && (k < 40)) begin
      cyc();
      k++;
    end
    if (k >= 40) dchk("drain_budget", 32'(k), 32'd0);
  endtask

  initial begin
    s_psel = '0; s_penable = '0; s_pwrite = '0; s_paddr = '0; s_pwdata = '0;
    for (int j = 0; j < NS; j++) m_prdata[j] = 32'hA000_0000 + 32'(j);
    m_pslverr = '0;
    m_pready  = '1;

    // Reset state
    @(negedge clk); @(negedge clk);
    dchk("rst_busy",    32'(busy_o),    32'd0);
    dchk("rst_grant",   32'(grant_o),   32'd0);
    dchk("rst_psel",    32'(m_psel),    32'd0);
    dchk("rst_penable", 32'(m_penable), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single zero-wait write, master0 -> slave2 (ptr 0 -> 1)
    req(0, 12'h010, 1'b1, 32'hCAFE_0001, 8'h04);
    exp_rsp(0, 32'hA000_0002, 1'b0);
    dchk("t1_c0_psel", 32'(m_psel), 32'd0);
    cyc();
    dchk("t1_c1_psel",    32'(m_psel),    32'h04);
    dchk("t1_c1_penable", 32'(m_penable), 32'd0);
    dchk("t1_c1_paddr",   32'(m_paddr),   32'h010);
    dchk("t1_c1_pwdata",  m_pwdata,       32'hCAFE_0001);
    dchk("t1_c1_pwrite",  32'(m_pwrite),  32'd1);
    dchk("t1_c1_grant",   32'(grant_o),   32'b01);
    cyc();
    dchk("t1_c2_penable", 32'(m_penable), 32'd1);
    dchk("t1_c2_pready",  32'(ack),       32'b01);
    cyc();
    dchk("t1_c3_busy",    32'(busy_o),    32'd0);
    dchk("t1_c3_psel",    32'(m_psel),    32'd0);
    drain();

    // Contention with ptr=1: master1 first, then master0
    req(0, 12'h020, 1'b0, 32'd0, 8'h02);
    req(1, 12'h030, 1'b1, 32'h1111_2222, 8'h08);
    exp_rsp(1, 32'hA000_0003, 1'b0);
    exp_rsp(0, 32'hA000_0001, 1'b0);
    cyc();
    dchk("t2_c1_grant", 32'(grant_o), 32'b10);
    dchk("t2_c1_psel",  32'(m_psel),  32'h08);
    cyc(); cyc();
    dchk("t2_c3_idle_psel", 32'(m_psel), 32'd0);
    dchk("t2_c3_idle_busy", 32'(busy_o), 32'd0);
    cyc();
    dchk("t2_c4_grant", 32'(grant_o), 32'b01);
    dchk("t2_c4_psel",  32'(m_psel),  32'h02);
    drain();

    // Read with three wait states and a slave error, master1 -> slave5
    m_prdata[5] = 32'h1234_5678;
    m_pslverr[5] = 1'b1;
    rdy_nxt[5] = 1'b0;
    req(1, 12'h050, 1'b0, 32'd0, 8'h20);
    exp_rsp(1, 32'h1234_5678, 1'b1);
    cyc(); cyc();
    dchk("t3_c2_wait", 32'(ack), 32'd0);
    cyc();
    dchk("t3_c3_wait", 32'(ack), 32'd0);
    cyc();
    dchk("t3_c4_wait",    32'(ack),       32'd0);
    dchk("t3_c4_penable", 32'(m_penable), 32'd1);
    rdy_nxt[5] = 1'b1;
    cyc();
    dchk("t3_c5_pready", 32'(ack), 32'b10);
    drain();
    m_prdata[5] = 32'hA000_0005;
    m_pslverr[5] = 1'b0;

    // Contention with ptr=0: master0 first, then master1
    req(0, 12'h064, 1'b0, 32'd0, 8'h40);
    req(1, 12'h078, 1'b0, 32'd0, 8'h80);
    exp_rsp(0, 32'hA000_0006, 1'b0);
    exp_rsp(1, 32'hA000_0007, 1'b0);
    cyc();
    dchk("t4_c1_grant", 32'(grant_o), 32'b01);
    cyc(); cyc(); cyc();
    dchk("t4_c4_grant", 32'(grant_o), 32'b10);
    drain();

    // Timeout: slave3 never readies, completion on the 4th ACCESS cycle
    rdy_nxt[3] = 1'b0;
    req(0, 12'h033, 1'b0, 32'd0, 8'h08);
    exp_rsp(0, 32'd0, 1'b1);
    cyc(); cyc(); cyc(); cyc();
    dchk("t5_c4_nopready", 32'(ack), 32'd0);
    cyc();
    dchk("t5_c5_pready", 32'(ack),    32'b01);
    dchk("t5_c5_psel",   32'(m_psel), 32'h08);
    cyc();
    dchk("t5_c6_psel",    32'(m_psel),    32'd0);
    dchk("t5_c6_penable", 32'(m_penable), 32'd0);
    rdy_nxt[3] = 1'b1;
    drain();

    // Malformed select from master1: error response, bus untouched
    req(1, 12'h066, 1'b1, 32'h5555_AAAA, 8'h06);
    exp_rsp(1, 32'd0, 1'b1);
    cyc();
    dchk("t6_c1_pready", 32'(ack),     32'b10);
    dchk("t6_c1_psel",   32'(m_psel),  32'd0);
    dchk("t6_c1_grant",  32'(grant_o), 32'b10);
    cyc();
    dchk("t6_c2_psel", 32'(m_psel), 32'd0);
    drain();

    // Plain write by master0 leaves ptr at 1 before the reset test
    req(0, 12'h004, 1'b1, 32'h0000_0BEE, 8'h01);
    exp_rsp(0, 32'hA000_0000, 1'b0);
    drain();

    // Reset while master0 is mid-ACCESS on a stalled slave4
    rdy_nxt[4] = 1'b0;
    req(0, 12'h044, 1'b1, 32'hDEAD_0044, 8'h10);
    cyc(); cyc(); cyc();
    dchk("t7_pre_penable", 32'(m_penable), 32'd1);
    rst = 1'b1;
    #1;
    dchk("t7_rst_penable", 32'(m_penable), 32'd0);
    dchk("t7_rst_psel",    32'(m_psel),    32'd0);
    dchk("t7_rst_busy",    32'(busy_o),    32'd0);
    dchk("t7_rst_grant",   32'(grant_o),   32'd0);
    dchk("t7_rst_paddr",   32'(m_paddr),   32'd0);
    dchk("t7_rst_pwdata",  m_pwdata,       32'd0);
    s_psel = '0; s_penable = '0; ack = '0; rdy_nxt = '1;
    cyc();
    rst = 1'b0;

    // After reset the pointer is 0: contention serves master0 first
    req(0, 12'h011, 1'b0, 32'd0, 8'h02);
    req(1, 12'h022, 1'b0, 32'd0, 8'h04);
    exp_rsp(0, 32'hA000_0001, 1'b0);
    exp_rsp(1, 32'hA000_0002, 1'b0);
    cyc();
    dchk("t8_c1_grant", 32'(grant_o), 32'b01);
    drain();

    // Fresh request from master1 alone
    req(1, 12'h077, 1'b0, 32'd0, 8'h80);
    exp_rsp(1, 32'hA000_0007, 1'b0);
    cyc();
    dchk("t9_c1_grant", 32'(grant_o), 32'b10);
    drain();

    end_req = 1'b1;
    for (int i = 0; (i < 10) && !mon_done; i++) @(posedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_mst_arbiter.md
Name: apb_mst_arbiter

Overview:
- Shares one APB bus and its APB_NUM_SLAVES slave peripherals between NUM_MST APB masters, for example the AXI-to-APB bridge plus a debug/config master.
- Arbitration is round-robin, at transfer granularity.
- The winner's transfer is registered and replayed downstream as a clean SETUP→ACCESS sequence.
- Each transfer is protected by a PREADY timeout, and malformed select vectors are rejected without touching the bus.

Parameters:
- NUM_MST, 2, number of upstream APB masters (≥2).
- APB_NUM_SLAVES, 8, width of the one-hot PSEL vector.
- APB_ADDR_WIDTH, 12, PADDR width.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- s_psel  in  [NUM_MST][APB_NUM_SLAVES]  upstream slave selects
- s_penable  in  [NUM_MST]  upstream enable
- s_pwrite  in  [NUM_MST]  upstream direction
- s_paddr  in  [NUM_MST][APB_ADDR_WIDTH]  upstream address
- s_pwdata  in  [NUM_MST][32]  upstream write data
- s_prdata  out  [NUM_MST][32]  read data returned to each master
- s_pready  out  [NUM_MST]  completion strobe to each master
- s_pslverr  out  [NUM_MST]  error returned to each master
- m_penable  out  1  downstream enable
- m_pwrite  out  1  downstream direction
- m_paddr  out  APB_ADDR_WIDTH  downstream address
- m_psel  out  APB_NUM_SLAVES  downstream one-hot select
- m_pwdata  out  32  downstream write data
- m_prdata  in  [APB_NUM_SLAVES][32]  slave read data
- m_pready  in  [APB_NUM_SLAVES]  slave ready
- m_pslverr  in  [APB_NUM_SLAVES]  slave error
- grant_o  out  NUM_MST  one-hot owner of the bus (0 when IDLE)
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_i=1):
  - State returns to IDLE and the round-robin pointer goes to 0.
  - All m_* outputs, s_pready, s_pslverr, s_prdata, grant_o and busy_o go to 0 immediately, even mid-transfer; the downstream transfer is abandoned.
- Request detection: req[i] = |s_psel[i].
- State machine:
  - IDLE:
    - If any req is set, the rr core picks the first requester at or after ptr (cyclic).
    - Register the winner's paddr, pwrite, pwdata and psel, plus the slave index (encoded psel).
    - If the winner's psel is one-hot, go to SETUP; otherwise go to ERR.
  - SETUP: m_psel = registered psel, m_penable=0, other m_* registered; timeout counter cleared; next state ACCESS.
  - ACCESS:
    - m_penable=1.
    - If m_pready[idx]=1: drive s_pready[win]=1, s_prdata[win]=m_prdata[idx], s_pslverr[win]=m_pslverr[idx] combinationally in the same cycle; set ptr=win+1 mod NUM_MST; go to IDLE.
    - Else, if TIMEOUT_CYCLES≠0 and count==TIMEOUT_CYCLES-1: complete in the same way but with s_pslverr=1 and s_prdata=0; drop m_psel/m_penable next cycle.
    - Else increment count.
  - ERR: one cycle of s_pready[win]=1, s_pslverr=1, s_prdata=0; no downstream activity; ptr=win+1; go to IDLE.
- Non-granted masters:
  - s_pready=0, so they wait in their ACCESS phase (legal APB wait states).
  - They are never starved: a requester gets the bus within NUM_MST transfers.
- Minimum latency: upstream SETUP at cycle 0, downstream SETUP at cycle 1, downstream ACCESS at cycle 2. Upstream PREADY occurs in cycle 2 if the slave is zero-wait.
- Back-to-back transfers: after a completion the state is IDLE for one cycle; a new request can be captured in that cycle, and m_psel is 0 in the IDLE cycle.
- If the winner drops psel before completion (protocol violation), the downstream transfer still completes and the response strobe is driven but ignored.
- s_pready is asserted only to the registered winner and only for one cycle per transfer.
- Counter width is $clog2(TIMEOUT_CYCLES+1), saturating (never wraps).

Decomposition:
- Package apb_arb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, ERR};
  - the APB data width constant (32);
  - a one-hot check function.
- Sub-module apb_rr_arb_core, parameterised by NUM_MST:
  - inputs req[NUM_MST] and ptr;
  - outputs the one-hot gnt and encoded gnt_idx, combinationally.
- The pointer register stays in the top module.

Test Plan:
- Single write: master0 writes PADDR=0x010, PWDATA=0xCAFE0001, psel=0x04; slave2 has zero wait → m_psel=0x04 in cycle 1, m_penable in cycle 2, s_pready[0] in cycle 2, busy_o back to 0 in cycle 3.
- Contention: masters 0 and 1 both request at cycle 0 with ptr=0 → master0 is served first, then master1; grant_o=01 then 10. Repeating with the pointer at 1 serves master1 first.
- Read with waits: master1 reads slave5 while it holds PREADY low for 3 cycles, then returns prdata=0x12345678 and pslverr=1 → s_prdata[1]=0x12345678 and s_pslverr[1]=1 in the same cycle as PREADY.
- Timeout: TIMEOUT_CYCLES=4 and the slave never readies → completion on the 4th ACCESS cycle with s_pslverr=1 and s_prdata=0; m_psel is 0 on the next cycle.
- Malformed select: psel=0x06 → ERR, s_pready=s_pslverr=1 one cycle later, m_psel never asserted.
- Reset mid-ACCESS: rst_i pulsed while m_penable=1 → all outputs are 0 in the same cycle. After release, a fresh request from master1 is served from ptr=0.
